// File: rtl/jtframe_ddram_arb.sv
// Two-requester round-robin burst-read arbiter for the MiSTer DDR3 Avalon read port.
// Grants one requester, issues its burst command, steers returned beats and pulses done at burst end.
module jtframe_ddram_arb #(
    parameter int AW  = 29,
    parameter int BCW = 8
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0,
    input  logic [AW-1:0]  addr0,
    input  logic [BCW-1:0] burst0,
    output logic           gnt0,
    output logic           rdy0,
    output logic           done0,

    input  logic           req1,
    input  logic [AW-1:0]  addr1,
    input  logic [BCW-1:0] burst1,
    output logic           gnt1,
    output logic           rdy1,
    output logic           done1,

    output logic [63:0]    dout,

    input  logic           ddram_busy,
    output logic           ddram_rd,
    output logic [AW-1:0]  ddram_addr,
    output logic [BCW-1:0] ddram_burstcnt,
    output logic [7:0]     ddram_be,
    input  logic [63:0]    ddram_dout,
    input  logic           ddram_dout_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t         state, state_nx;
    // last_win doubles as the current owner whenever state is not IDLE
    logic           last_win, last_win_nx;
    logic [AW-1:0]  addr_nx;
    logic [BCW-1:0] bcnt_nx, blen;
    logic [BCW-1:0] cnt, cnt_nx, cnt_inc;
    logic           done0_nx, done1_nx;
    logic           beat, win;

    assign beat     = ddram_dout_ready && state == DATA;
    assign cnt_inc  = cnt + BCW'(1);
    assign gnt0     = state != IDLE && !last_win;
    assign gnt1     = state != IDLE &&  last_win;
    assign rdy0     = beat && !last_win;
    assign rdy1     = beat &&  last_win;
    assign ddram_rd = state == ISSUE;
    assign ddram_be = 8'hFF;
    assign dout     = ddram_dout;

    always_comb begin
        state_nx    = state;
        last_win_nx = last_win;
        addr_nx     = ddram_addr;
        bcnt_nx     = ddram_burstcnt;
        cnt_nx      = cnt;
        done0_nx    = 1'b0;
        done1_nx    = 1'b0;
        win         = (req0 && req1) ? !last_win : req1;
        blen        = win ? burst1 : burst0;
        case (state)
            // The done cycle is not an arbitration cycle, so the finishing
            // requester gets a cycle to drop req before the next win.
            IDLE: if ((req0 || req1) && !done0 && !done1) begin
                state_nx    = ISSUE;
                last_win_nx = win;
                addr_nx     = win ? addr1 : addr0;
                bcnt_nx     = (blen == '0) ? BCW'(1) : blen;
            end
            ISSUE: if (!ddram_busy) state_nx = DATA;
            DATA: if (beat) begin
                if (cnt_inc == ddram_burstcnt) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    done0_nx = !last_win;
                    done1_nx =  last_win;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_win       <= 1'b1;
            ddram_addr     <= '0;
            ddram_burstcnt <= BCW'(1);
            cnt            <= '0;
            done0          <= 1'b0;
            done1          <= 1'b0;
        end else begin
            state          <= state_nx;
            last_win       <= last_win_nx;
            ddram_addr     <= addr_nx;
            ddram_burstcnt <= bcnt_nx;
            cnt            <= cnt_nx;
            done0          <= done0_nx;
            done1          <= done1_nx;
        end
    end

endmodule

// File: doc/jtframe_ddram_arb.md
Name: jtframe_ddram_arb

Overview:
Two-requester burst-read arbiter for the MiSTer DDR3 Avalon read port. Requester 0 is the ROM-dump path from DDR to the SDRAM loader; requester 1 is a core-side streaming reader, e.g. sample or tile prefetch. The block grants one requester at a time and issues its burst read command. It counts the returned beats, steers the data-valid strobe to the owner, and releases the port at burst end. Round-robin priority prevents either side from starving the other.

Parameters:
AW, 29, DDR word address width (64-bit words)
BCW, 8, burst count width; legal bursts are 1..128

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  reset, asynchronous, active-high
req0  in  1  requester 0 read request; level, held until done0
addr0  in  AW  requester 0 burst start address; sampled at grant
burst0  in  BCW  requester 0 burst length; sampled at grant
gnt0  out  1  requester 0 owns the port
rdy0  out  1  data beat valid for requester 0
done0  out  1  one-cycle pulse: requester 0 burst complete
req1, addr1, burst1, gnt1, rdy1, done1  same widths and meanings, requester 1
dout  out  64  shared read data; combinational copy of ddram_dout
ddram_busy  in  1  Avalon waitrequest
ddram_rd  out  1  Avalon read command
ddram_addr  out  AW  latched burst address
ddram_burstcnt  out  BCW  latched burst length
ddram_be  out  8  constant 8'hFF
ddram_dout  in  64  read data
ddram_dout_ready  in  1  read data valid

Behaviour:
- Reset values: gnt0/1=0, ddram_rd=0, rdy0/1=0, done0/1=0, ddram_addr=0, ddram_burstcnt=1, beat counter=0, last-winner=1 (requester 0 wins first). Reset mid-burst aborts immediately; beats from the aborted burst arrive in IDLE and are dropped.
- FSM states: IDLE, ISSUE, DATA.
- IDLE:
  - With exactly one req high, that requester wins.
  - With both req high, the requester that is not last-winner wins.
  - On a win, next cycle: gntN=1, ddram_rd=1, ddram_addr/burstcnt latched, state goes to ISSUE, last-winner is updated.
  - A burst value of 0 is latched as 1.
- ISSUE:
  - ddram_rd stays high until a cycle with ddram_busy=0; that cycle is the command acceptance.
  - The cycle after acceptance: ddram_rd=0, state goes to DATA.
  - ddram_addr and ddram_burstcnt are stable for the whole of ISSUE.
- DATA:
  - Each ddram_dout_ready=1 beat gives rdyN=ddram_dout_ready for the owner only. This is combinational, same cycle as the beat, gated by gntN and state DATA.
  - Each beat increments the beat counter.
  - When the beat count reaches the latched burst length, next cycle: doneN=1 for one cycle, gntN=0, counter cleared, state goes to IDLE.
- Beats outside DATA never assert rdy0 or rdy1.
- ddram_dout_ready arriving in ISSUE in the same cycle as acceptance (zero-latency model) is not counted. Avalon forbids this, and the bench must not generate it.
- Dropping req during ISSUE or DATA does not cancel the burst; it completes and done still pulses.
- A requester that keeps req high after done is re-arbitrated:
  - It wins again if the other requester is idle.
  - Otherwise the other requester wins.
- Minimum turnaround is done cycle, then IDLE arbitration, then new gnt: 2 cycles from done to the next ddram_rd.
- gnt0 and gnt1 are never high together; gntN is 1 from the cycle after the win through the done cycle exclusive.
- ddram_be is always 8'hFF.

Test Plan:
- Single request: req0=1, addr0=29'h0600_0000, burst0=4, busy=0, 4 beats 2 cycles after accept.
  Required: gnt0 and ddram_rd high 1 cycle after req0, rd high exactly 1 cycle, rdy0 pulses 4 times, rdy1 never, done0 1 cycle after 4th beat, then gnt0=0.
- Waitrequest: busy=1 for 5 cycles after rd rises.
  Required: ddram_rd held 6 cycles, addr and burstcnt stable throughout, data phase identical to the single-request case.
- Contention: req0 and req1 both held, burst=2 each, 6 bursts total.
  Required: grant order 0,1,0,1,0,1; each done precedes the next rd by exactly 2 cycles.
- Release mid-burst: req1 burst1=128, drop req1 after 10 beats.
  Required: all 128 rdy1 pulses, done1 once, then IDLE with gnt1=0.
- Burst of 0 and stray beats: burst0=0 yields burstcnt=1 and a single rdy0. A ready pulse injected in IDLE yields no rdy0 or rdy1.
- Reset mid-burst: assert rst at beat 3 of 8, release, feed the remaining 5 beats.
  Required: all outputs 0 at once, no rdy pulses; a subsequent req1-only request is granted normally.
